// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between N_REQ
// producers. Each grant sends an optional tag byte, then the word LSB and MSB.
module uart_tx_arbiter #(
  parameter int N_REQ            = 4,
  parameter int INTER_BYTE_DELAY = 1000000,
  parameter bit SEND_HEADER      = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [16*N_REQ-1:0]      data_in,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     busy
);

  localparam int          IDW      = $clog2(N_REQ);
  localparam logic [31:0] GAP_LAST = (INTER_BYTE_DELAY > 1) ? 32'(INTER_BYTE_DELAY - 1) : 32'd0;
  localparam logic [1:0]  LAST_IDX = SEND_HEADER ? 2'd2 : 2'd1;

  typedef enum logic [1:0] {IDLE, SEND, DRV_WAIT, GAP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [15:0]      word_q;
  logic [IDW-1:0]   grant_q, last_q;
  logic [1:0]       bidx_q;
  logic [7:0]       txd_q;
  logic [N_REQ-1:0] ack_q;
  logic             drv_first_q;

  logic [IDW-1:0]   pick;
  logic             found;
  logic [15:0]      sel_word;
  logic             gap_done;

  function automatic logic [7:0] frame_byte(input logic [15:0]    w,
                                            input logic [IDW-1:0] id,
                                            input logic [1:0]     idx);
    logic [3:0] id4;
    logic [7:0] b;
    id4 = 4'(id);
    if (SEND_HEADER) begin
      case (idx)
        2'd0:    b = {4'hA, id4};
        2'd1:    b = w[7:0];
        default: b = w[15:8];
      endcase
    end else begin
      b = (idx == 2'd0) ? w[7:0] : w[15:8];
    end
    return b;
  endfunction

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx  = (int'(last_q) + i) % N_REQ;
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_word = data_in[{pick, 4'b0000} +: 16];
  assign gap_done = (cnt_q == GAP_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (found) state_d = SEND;
      SEND:     if (!tx_busy) state_d = DRV_WAIT;
      DRV_WAIT: if (!drv_first_q && !tx_busy) state_d = GAP;
      GAP:      if (gap_done) state_d = (bidx_q == LAST_IDX) ? IDLE : SEND;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state_q == SEND) && !tx_busy;
    busy     = (state_q != IDLE);
  end

  assign cnt_d    = (state_q == GAP && !gap_done) ? cnt_q + 32'd1 : 32'd0;
  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign tx_data  = txd_q;

  // drv_first_q marks the first DRV_WAIT cycle, giving the driver time to raise busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 32'd0;
      word_q      <= 16'd0;
      grant_q     <= '0;
      last_q      <= IDW'(N_REQ - 1);
      bidx_q      <= 2'd0;
      txd_q       <= 8'd0;
      ack_q       <= '0;
      drv_first_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ack_q       <= '0;
      drv_first_q <= tx_start;
      if (state_q == IDLE && found) begin
        word_q  <= sel_word;
        grant_q <= pick;
        last_q  <= pick;
        bidx_q  <= 2'd0;
        txd_q   <= frame_byte(sel_word, pick, 2'd0);
        ack_q   <= N_REQ'(1) << pick;
      end else if (state_q == GAP && gap_done && bidx_q != LAST_IDX) begin
        bidx_q <= bidx_q + 2'd1;
        txd_q  <= frame_byte(word_q, grant_q, bidx_q + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a header/delay-5 instance with a 10-cycle driver
// model, and a headerless zero-delay instance with an always-ready driver.
module tb_uart_tx_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n;
  logic [3:0]  req0, req1, ack0, ack1;
  logic [63:0] data0, data1;
  logic [1:0]  gid0, gid1;
  logic [7:0]  txd0, txd1;
  logic        txs0, txs1, txb0, txb1, busy0, busy1;
  logic        force_busy;
  int          drv_cnt;
  int          cyc = 0;

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$], q1[$];
  int         sp0[$], sp1[$];
  int         starts0 = 0;
  int         last0 = 0, last1 = 0;
  logic       prev0 = 1'b0, prev1 = 1'b0;

  assign txb0 = force_busy || (drv_cnt != 0);
  assign txb1 = 1'b0;

  uart_tx_arbiter #(.N_REQ(4), .INTER_BYTE_DELAY(5), .SEND_HEADER(1'b1)) dut0 (
    .clock(clock), .reset(rst_n), .req(req0), .data_in(data0), .ack(ack0),
    .grant_id(gid0), .tx_data(txd0), .tx_start(txs0), .tx_busy(txb0), .busy(busy0));

  uart_tx_arbiter #(.N_REQ(4), .INTER_BYTE_DELAY(0), .SEND_HEADER(1'b0)) dut1 (
    .clock(clock), .reset(rst_n), .req(req1), .data_in(data1), .ack(ack1),
    .grant_id(gid1), .tx_data(txd1), .tx_start(txs1), .tx_busy(txb1), .busy(busy1));

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n)          drv_cnt <= 0;
    else if (txs0)       drv_cnt <= 10;
    else if (drv_cnt > 0) drv_cnt <= drv_cnt - 1;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push0(input logic [1:0] id, input logic [15:0] w);
    q0.push_back({4'hA, 2'b00, id}); sp0.push_back(0);
    q0.push_back(w[7:0]);            sp0.push_back(17);
    q0.push_back(w[15:8]);           sp0.push_back(17);
  endtask

  always @(negedge clock) begin
    if (rst_n && txs0) begin
      starts0++;
      chk("dut0_start_while_busy", txb0, 1'b0);
      chk("dut0_start_back_to_back", prev0, 1'b0);
      if (q0.size() == 0) begin
        chk("dut0_unexpected_byte", 1'b1, 1'b0);
      end else begin
        automatic logic [7:0] eb = q0.pop_front();
        automatic int es = sp0.pop_front();
        chk("dut0_byte", txd0, eb);
        if (es != 0) chk("dut0_spacing", cyc - last0, es);
      end
      last0 = cyc;
    end
    prev0 = rst_n && txs0;
  end

  always @(negedge clock) begin
    if (rst_n && txs1) begin
      chk("dut1_start_back_to_back", prev1, 1'b0);
      if (q1.size() == 0) begin
        chk("dut1_unexpected_byte", 1'b1, 1'b0);
      end else begin
        automatic logic [7:0] eb = q1.pop_front();
        automatic int es = sp1.pop_front();
        chk("dut1_byte", txd1, eb);
        if (es != 0) chk("dut1_spacing", cyc - last1, es);
      end
      last1 = cyc;
    end
    prev1 = rst_n && txs1;
  end

  task automatic wait_ack0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      if (ack0 != 4'b0) ok = 1'b1;
    end
  endtask

  task automatic wait_idle0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      if (!busy0) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    logic        drop;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_id;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vt[8];

  initial begin
    bit ok;
    int base;
    bit seen;

    vt[0] = '{4'b1111, 64'h0003_0002_0001_0000, 1'b0, 4'b0001, 2'd0, 16'h0000};
    vt[1] = '{4'b1111, 64'h0003_0002_0001_0000, 1'b0, 4'b0010, 2'd1, 16'h0001};
    vt[2] = '{4'b1111, 64'h0003_0002_0001_0000, 1'b0, 4'b0100, 2'd2, 16'h0002};
    vt[3] = '{4'b1111, 64'h0003_0002_0001_0000, 1'b0, 4'b1000, 2'd3, 16'h0003};
    vt[4] = '{4'b1111, 64'h0003_0002_0001_0000, 1'b0, 4'b0001, 2'd0, 16'h0000};
    vt[5] = '{4'b0100, 64'h0000_1234_0000_0000, 1'b0, 4'b0100, 2'd2, 16'h1234};
    vt[6] = '{4'b0100, 64'h0000_1234_0000_0000, 1'b0, 4'b0100, 2'd2, 16'h1234};
    vt[7] = '{4'b0010, 64'h0000_0000_7788_0000, 1'b1, 4'b0010, 2'd1, 16'h7788};

    rst_n = 1'b0; req0 = '0; req1 = '0; data0 = '0; data1 = '0; force_busy = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ack", ack0, 4'b0);
    chk("rst_gid", gid0, 2'd0);
    chk("rst_txd", txd0, 8'h00);
    chk("rst_txs", txs0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    @(posedge clock); #1 rst_n = 1'b1;

    // Table-driven frames: round robin, lone requester, early drop.
    for (int v = 0; v < 8; v++) begin
      req0 = vt[v].req; data0 = vt[v].data;
      push0(vt[v].exp_id, vt[v].exp_word);
      wait_ack0(ok);
      chk("ack_seen", ok, 1'b1);
      chk("ack_value", ack0, vt[v].exp_ack);
      chk("grant_id", gid0, vt[v].exp_id);
      @(negedge clock);
      chk("ack_one_cycle", ack0, 4'b0);
      if (vt[v].drop) req0 = '0;
      wait_idle0(ok);
      chk("frame_done", ok, 1'b1);
    end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (ack0 != 4'b0) seen = 1'b1;
    end
    chk("no_regrant_after_drop", seen, 1'b0);

    // Driver stall while in SEND.
    force_busy = 1'b1; req0 = 4'b1000; data0 = 64'h5A5A_0000_0000_0000;
    push0(2'd3, 16'h5A5A);
    wait_ack0(ok);
    chk("stall_ack_seen", ok, 1'b1);
    chk("stall_gid", gid0, 2'd3);
    chk("stall_no_start_ack_cycle", txs0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("stall_no_start", txs0, 1'b0);
      chk("stall_busy", busy0, 1'b1);
    end
    @(posedge clock); #1 force_busy = 1'b0; req0 = '0;
    @(negedge clock);
    chk("stall_release_start", txs0, 1'b1);
    wait_idle0(ok);
    chk("stall_frame_done", ok, 1'b1);

    // Reset during the GAP after the LSB; the held request restarts cleanly.
    base = starts0;
    req0 = 4'b0010; data0 = 64'h0000_0000_CAFE_0000;
    q0.push_back(8'hA1); sp0.push_back(0);
    q0.push_back(8'hFE); sp0.push_back(17);
    wait_ack0(ok);
    chk("mid_ack_seen", ok, 1'b1);
    chk("mid_gid", gid0, 2'd1);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      if (starts0 >= base + 2) ok = 1'b1;
    end
    chk("mid_lsb_sent", ok, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (!txb0) ok = 1'b1;
    end
    chk("mid_driver_free", ok, 1'b1);
    @(posedge clock); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_txs", txs0, 1'b0);
    chk("mid_rst_ack", ack0, 4'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_gid", gid0, 2'd0);
    chk("mid_rst_txd", txd0, 8'h00);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    q0.push_back(8'hA1); sp0.push_back(0);
    q0.push_back(8'hFE); sp0.push_back(17);
    q0.push_back(8'hCA); sp0.push_back(17);
    wait_ack0(ok);
    chk("post_rst_ack_seen", ok, 1'b1);
    chk("post_rst_ack", ack0, 4'b0010);
    chk("post_rst_gid", gid0, 2'd1);
    @(negedge clock); req0 = '0;
    wait_idle0(ok);
    chk("post_rst_frame_done", ok, 1'b1);

    // Headerless, zero-delay instance: two bytes, one-cycle GAPs.
    req1 = 4'b0001; data1 = 64'h0000_0000_0000_BEEF;
    q1.push_back(8'hEF); sp1.push_back(0);
    q1.push_back(8'hBE); sp1.push_back(4);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (ack1 != 4'b0) ok = 1'b1;
    end
    chk("hl_ack_seen", ok, 1'b1);
    chk("hl_ack", ack1, 4'b0001);
    chk("hl_gid", gid1, 2'd0);
    chk("hl_first_start", txs1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) req1 = '0;
      chk("hl_busy_window", busy1, (k < 8) ? 1'b1 : 1'b0);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (ack1 != 4'b0 || busy1) seen = 1'b1;
    end
    chk("hl_stays_idle", seen, 1'b0);

    chk("dut0_bytes_all_sent", q0.size(), 0);
    chk("dut1_bytes_all_sent", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART byte transmitter between up to `N_REQ` requesters, each presenting a 16-bit result word. For every granted request it latches the word and sends a frame over the byte-wide UART driver interface, waiting for the driver and an inter-byte gap between bytes. The frame is an optional tag byte naming the requester, then the LSB, then the MSB. It sits between the ALU/result producers and the UART TX driver, and replaces per-producer TX control when several sources share the serial link.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `INTER_BYTE_DELAY`, 1000000: idle clock cycles after each byte once the driver is free; a value of 0 is treated as 1.
- `SEND_HEADER`, 1: 1 sends the tag byte `{4'hA, id[3:0]}` before the data bytes; 0 sends data bytes only.

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `req`  in  N_REQ  level request; bit i set means requester i has a word to send.
- `data_in`  in  16*N_REQ  flattened words; requester i uses bits [16i+15:16i].
- `ack`  out  N_REQ  one-hot, one-cycle pulse marking the requester whose word was just latched.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester.
- `tx_data`  out  8  byte presented to the UART driver.
- `tx_start`  out  1  one-cycle pulse that starts transmission of `tx_data`.
- `tx_busy`  in  1  UART driver is transmitting.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SEND, DRV_WAIT, GAP.
- **IDLE**
  - If any `req` bit is set, the arbiter picks the first set bit at or after `(last_grant+1) mod N_REQ`.
  - At that edge it latches the word, sets `grant_id` and `last_grant`, clears byte index `bidx` to 0, and moves to SEND.
  - `ack[grant]` is high for exactly the first SEND cycle.
- **SEND**
  - The byte for `bidx` is held on `tx_data`: tag (bidx 0 when `SEND_HEADER`=1), then word[7:0], then word[15:8].
  - If `tx_busy`=0: `tx_start`=1 for this cycle, then move to DRV_WAIT.
  - If `tx_busy`=1: hold in SEND with `tx_start`=0.
- **DRV_WAIT**
  - `tx_busy` is ignored in the first cycle, so the driver has one cycle to raise busy.
  - From the second cycle on, `tx_busy`=0 moves to GAP.
- **GAP**
  - Counts `max(INTER_BYTE_DELAY,1)` cycles using a 32-bit counter, which is cleared in every other state.
  - After the count: if `bidx` is the last byte (index 2 with header, 1 without), move to IDLE; otherwise increment `bidx` and move to SEND.
- `tx_data` is registered, is loaded on entry to SEND, and stays stable through DRV_WAIT and GAP.
- `req` is not re-sampled during a frame.
  - A requester that keeps `req` high is arbitrated again in IDLE after its frame completes.
  - A requester that drops `req` after `ack` still has its frame completed.
- Round-robin fairness: with all requesters active, the grant order is 0,1,…,N_REQ-1,0,…
- A requester with no competitors is re-granted on every frame.
- `last_grant` resets to N_REQ-1, so requester 0 wins the first contested arbitration.

## Timing
- Reset (`reset`=0, asynchronous):
  - State returns to IDLE and `bidx`, counter and `tx_data` clear to 0.
  - `tx_start`=0, `ack`=0, `busy`=0, `grant_id`=0, `last_grant`=N_REQ-1.
  - A frame in progress is abandoned and no further `tx_start` is issued.
  - After release, operation resumes on the first rising edge with `reset`=1.
- Latency: `req` sampled in IDLE at edge k gives `ack` and `tx_start` in cycle k+1, when `tx_busy`=0.
- `tx_start` is never high for two consecutive cycles, and never while `tx_busy`=1.
- Minimum start-to-start spacing between bytes within a frame is 1 (SEND) + DRV_WAIT length + max(INTER_BYTE_DELAY,1) cycles.
- A frame ends with the full GAP after its last byte. IDLE then lasts at least one cycle before the next grant, so `busy` drops for at least one cycle between frames.
- A `req` bit rising in the same cycle the FSM enters IDLE is seen at the next edge.

## Test plan
- **Single-requester frame.** Setup: reset, `N_REQ`=4, `SEND_HEADER`=1, `INTER_BYTE_DELAY`=5, driver model busy for 10 cycles per byte. Stimulus: `req`=4'b0100 with word 16'h1234. Required: `ack`=4'b0100 pulses once, `grant_id`=2, bytes 0xA2, 0x34, 0x12 each with one `tx_start`, `busy` returns to 0.
- **Round-robin with all active.** Stimulus: `req`=4'b1111 held, words 16'h0000+i. Required: grants in order 0,1,2,3,0, with tag bytes 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
- **Driver stall.** Stimulus: `tx_busy` forced to 1 while the FSM is in SEND for 20 cycles. Required: no `tx_start` during the stall, and `tx_start` in the first cycle after `tx_busy` falls.
- **Headerless, zero delay.** Setup: `SEND_HEADER`=0, `INTER_BYTE_DELAY`=0. Stimulus: word 16'hBEEF. Required: exactly 2 bytes, 0xEF then 0xBE, each GAP exactly 1 cycle.
- **Reset mid-frame.** Stimulus: `reset`=0 asserted during the GAP after the LSB. Required: all outputs 0 immediately and no MSB sent. After release, the held `req` of requester 1 is granted with `grant_id`=1 and its full frame is sent.
- **Early request drop.** Stimulus: `req` dropped in the cycle after `ack`. Required: the full frame is still transmitted and there is no second grant to that requester.
